// File: rtl/bram_display_scanner.sv
// Read-side sequencer for a BRAM display port: walks an address window, captures each
// word, and holds it on display_value for DWELL_CYCLES before fetching the next one.
module bram_display_scanner #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    input  logic                  run,
    input  logic                  pause,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] display_value,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic                  word_valid
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_display_scanner: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        dwell_cnt;
    logic                    advance;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // A paused scanner only moves on an explicit step; an unpaused one on dwell expiry.
    always_comb begin
        advance   = (!pause && (dwell_cnt == DWELL_LAST)) || (pause && step);
        next_addr = (rd_addr == last_addr) ? base_addr : rd_addr + ADDR_WIDTH'(1);
    end

    // NOTE: all state and outputs update with non-blocking assignments so every branch
    // below sees the values from the start of the cycle, independent of statement order.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            // NOTE: display_value/word_addr are plain registers, not a RAM, so clearing
            // them on reset is cheap and gives the display a defined blank value.
            state         <= S_IDLE;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            display_value <= '0;
            word_addr     <= '0;
            word_valid    <= 1'b0;
            dwell_cnt     <= '0;
        end else begin
            rd_en      <= 1'b0;
            word_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (run) begin
                        rd_addr <= base_addr;
                        rd_en   <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= (READ_LATENCY == 2) ? S_WAIT : S_CAPTURE;
                end
                S_WAIT: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    display_value <= rd_data;
                    word_addr     <= rd_addr;
                    word_valid    <= 1'b1;
                    dwell_cnt     <= '0;
                    state         <= S_HOLD;
                end
                S_HOLD: begin
                    // Dropping run wins over an advance so no read is left half-issued.
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (advance) begin
                        rd_addr <= next_addr;
                        rd_en   <= 1'b1;
                        state   <= S_ISSUE;
                    end else if (!pause) begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_display_scanner.sv
// Directed bench for bram_display_scanner: two instances (read latency 1 and 2) share
// the same stimulus, each fed by its own BRAM model with mem[i] = 32'h11111111 * i.
module tb_bram_display_scanner;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run, pause, step;
    logic [AW-1:0] base_addr, last_addr;

    logic          rd_en1, rd_en2, wv1, wv2;
    logic [AW-1:0] rd_addr1, rd_addr2, waddr1, waddr2;
    logic [DW-1:0] rd_data1, rd_data2, disp1, disp2;
    logic [DW-1:0] d2_stage;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_display_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .DWELL_CYCLES(4)) dut1 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .run(run), .pause(pause), .step(step),
        .base_addr(base_addr), .last_addr(last_addr), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .display_value(disp1), .word_addr(waddr1), .word_valid(wv1)
    );

    bram_display_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .DWELL_CYCLES(4)) dut2 (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .run(run), .pause(pause), .step(step),
        .base_addr(base_addr), .last_addr(last_addr), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .display_value(disp2), .word_addr(waddr2), .word_valid(wv2)
    );

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return 32'h11111111 * DW'(a);
    endfunction

    // BRAM models: latency 1 has only the array read register, latency 2 adds DO_REG.
    always_ff @(posedge clk) begin
        if (rd_en1) rd_data1 <= mem_val(rd_addr1);
        if (rd_en2) d2_stage <= mem_val(rd_addr2);
        rd_data2 <= d2_stage;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the chosen instance pulses word_valid; a timeout returns the limit.
    task automatic wait_valid(input int which, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (((which == 1) ? wv1 : wv2) !== 1'b1 && n < 20);
    endtask

    logic [DW-1:0] scan_vals [5] = '{32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0};
    logic [AW-1:0] wrap_addrs[5] = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd1022};
    logic [DW-1:0] wrap_vals [5] = '{32'h222221DE, 32'h333332EF, 32'h0, 32'h11111111, 32'h222221DE};

    initial begin
        int n;
        rst_n = 1'b0; run = 1'b1; pause = 1'b0; step = 1'b0;
        base_addr = 10'd0; last_addr = 10'd3;
        @(negedge clk);

        // 1. reset held with run=1
        repeat (3) cyc();
        check("rst_rd_en", 64'(rd_en1), 64'd0);
        check("rst_rd_addr", 64'(rd_addr1), 64'd0);
        check("rst_display", 64'(disp1), 64'd0);
        check("rst_word_valid", 64'(wv1), 64'd0);
        check("rst_word_addr", 64'(waddr1), 64'd0);
        rst_n = 1'b1;
        check("release_idle_rd_en", 64'(rd_en1), 64'd0);
        cyc();
        check("release_issue_rd_en", 64'(rd_en1), 64'd1);
        check("release_issue_addr", 64'(rd_addr1), 64'd0);

        // 2. basic scan, latency 1, period 6
        wait_valid(1, n);
        check("l1_first_latency", 64'(n), 64'd2);
        check("l1_addr0", 64'(waddr1), 64'd0);
        check("l1_val0", 64'(disp1), 64'(scan_vals[0]));
        cyc();
        check("l1_pulse_width", 64'(wv1), 64'd0);
        for (int i = 1; i < 5; i++) begin
            wait_valid(1, n);
            check("l1_period", 64'(n), (i == 1) ? 64'd5 : 64'd6);
            check("l1_addr", 64'(waddr1), 64'(i % 4));
            check("l1_val", 64'(disp1), 64'(scan_vals[i]));
        end

        // 3. latency 2, period 7
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("l2_issue_rd_en", 64'(rd_en2), 64'd1);
        cyc();
        check("l2_wait_rd_en", 64'(rd_en2), 64'd0);
        wait_valid(2, n);
        check("l2_first_latency", 64'(n), 64'd2);
        check("l2_addr0", 64'(waddr2), 64'd0);
        check("l2_val0", 64'(disp2), 64'(scan_vals[0]));
        for (int i = 1; i < 5; i++) begin
            wait_valid(2, n);
            check("l2_period", 64'(n), 64'd7);
            check("l2_addr", 64'(waddr2), 64'(i % 4));
            check("l2_val", 64'(disp2), 64'(scan_vals[i]));
        end

        // 4a. window through the top of memory
        base_addr = 10'd1022; last_addr = 10'd1;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("wrap_issue_addr", 64'(rd_addr1), 64'd1022);
        for (int i = 0; i < 5; i++) begin
            wait_valid(1, n);
            check("wrap_period", 64'(n), (i == 0) ? 64'd2 : 64'd6);
            check("wrap_addr", 64'(waddr1), 64'(wrap_addrs[i]));
            check("wrap_val", 64'(disp1), 64'(wrap_vals[i]));
        end

        // 4b. single-word window
        base_addr = 10'd5; last_addr = 10'd5;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        wait_valid(1, n);
        for (int i = 0; i < 3; i++) begin
            wait_valid(1, n);
            check("single_period", 64'(n), 64'd6);
            check("single_addr", 64'(waddr1), 64'd5);
            check("single_rd_addr", 64'(rd_addr1), 64'd5);
            check("single_val", 64'(disp1), 64'h55555555);
        end

        // 5. pause / step
        base_addr = 10'd0; last_addr = 10'd3;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        wait_valid(1, n);
        wait_valid(1, n);
        check("ps_word1", 64'(disp1), 64'h11111111);
        cyc();
        cyc();
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("ps_frozen_rd_en", 64'(rd_en1), 64'd0);
            check("ps_frozen_val", 64'(disp1), 64'h11111111);
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_rd_en", 64'(rd_en1), 64'd1);
        check("step_rd_addr", 64'(rd_addr1), 64'd2);
        cyc();
        check("step_capture_wv", 64'(wv1), 64'd0);
        cyc();
        check("step_wv", 64'(wv1), 64'd1);
        check("step_addr", 64'(waddr1), 64'd2);
        check("step_val", 64'(disp1), 64'h22222222);
        // one counted cycle, then freeze at count 1; resume needs only 3 more cycles
        pause = 1'b0;
        cyc();
        pause = 1'b1;
        repeat (5) begin
            cyc();
            check("refreeze_rd_en", 64'(rd_en1), 64'd0);
        end
        pause = 1'b0;
        step = 1'b1;
        n = 0;
        do begin
            cyc();
            step = 1'b0;
            n++;
        end while (rd_en1 !== 1'b1 && n < 20);
        check("resume_cycles", 64'(n), 64'd3);
        check("resume_rd_addr", 64'(rd_addr1), 64'd3);

        // 6. run drop in HOLD, run ignored mid-read, reset in ISSUE
        cyc();
        cyc();
        check("w3_wv", 64'(wv1), 64'd1);
        check("w3_val", 64'(disp1), 64'h33333333);
        run = 1'b0;
        repeat (3) begin
            cyc();
            check("idle_rd_en", 64'(rd_en1), 64'd0);
            check("idle_keep_val", 64'(disp1), 64'h33333333);
            check("idle_keep_addr", 64'(waddr1), 64'd3);
        end
        run = 1'b1;
        cyc();
        check("restart_rd_en", 64'(rd_en1), 64'd1);
        check("restart_addr", 64'(rd_addr1), 64'd0);
        run = 1'b0;
        cyc();
        cyc();
        check("late_stop_wv", 64'(wv1), 64'd1);
        check("late_stop_addr", 64'(waddr1), 64'd0);
        cyc();
        check("late_stop_idle", 64'(rd_en1), 64'd0);
        run = 1'b1;
        cyc();
        check("pre_reset_rd_en", 64'(rd_en1), 64'd1);
        rst_n = 1'b0;
        cyc();
        check("midrst_rd_en", 64'(rd_en1), 64'd0);
        check("midrst_rd_addr", 64'(rd_addr1), 64'd0);
        check("midrst_val", 64'(disp1), 64'd0);
        check("midrst_word_addr", 64'(waddr1), 64'd0);
        rst_n = 1'b1;
        run = 1'b0;
        repeat (4) begin
            cyc();
            check("midrst_no_wv", 64'(wv1), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
